// File: rtl/onchip_mem_loader_pkg.sv
// Shared types and defaults for the on-chip RAM stream loader.
package onchip_mem_loader_pkg;

  localparam int ADDR_W_DEF      = 15;
  localparam int LEN_W_DEF       = 17;
  localparam int DEPTH_WORDS_DEF = 32768;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_VRD,
    S_VCMP,
    S_FINISH
  } loader_state_e;

  // Expands a 4-bit byteenable into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/onchip_mem_stream_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into one 32-bit word with byteenables.
module byte_packer
  import onchip_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        take_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [3:0]  be_o,
  output logic        word_full_o
);

  logic [31:0] word_q, word_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  lane_q, lane_d;

  always_comb begin
    word_d = word_q;
    be_d   = be_q;
    lane_d = lane_q;
    if (clear_i) begin
      word_d = '0;
      be_d   = '0;
      lane_d = '0;
    end else if (take_i) begin
      word_d[8*lane_q +: 8] = byte_i;
      be_d[lane_q]          = 1'b1;
      lane_d                = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      be_q   <= '0;
      lane_q <= '0;
    end else begin
      word_q <= word_d;
      be_q   <= be_d;
      lane_q <= lane_d;
    end
  end

  assign word_o      = word_q;
  assign be_o        = be_q;
  assign word_full_o = take_i && (lane_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// Streams a byte image into the on-chip RAM s1 port as packed 32-bit writes.
// Build option ONCHIP_MEM_LOADER_VERIFY_EN adds a read-back compare after each write.
module onchip_mem_stream_loader
  import onchip_mem_loader_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [LEN_W-1:0]  cmd_byte_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [7:0]        st_data,
  input  logic              st_valid,
  output logic              st_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  loader_state_e     state_q;
  logic              busy_q, done_q, error_q, st_ready_q, cs_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;

  logic              take, word_full, last_byte, write_end;
  logic [31:0]       pk_word;
  logic [3:0]        pk_be;
  logic [LEN_W:0]    words_needed, span_end;
  logic              out_of_range;

  // Range check is done one bit wider so base + words cannot overflow.
  assign words_needed = ({1'b0, cmd_byte_len} + (LEN_W+1)'(BYTES_PER_WORD - 1))
                        >> $clog2(BYTES_PER_WORD);
  assign span_end     = (LEN_W+1)'(cmd_base_addr) + words_needed;
  assign out_of_range = span_end > (LEN_W+1)'(DEPTH_WORDS);

  assign take      = st_ready_q && st_valid;
  assign last_byte = (rem_q == LEN_W'(1));

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
  logic mismatch;
  assign mismatch  = |((mem_readdata ^ pk_word) & lane_mask(pk_be));
  assign write_end = (state_q == S_VCMP);
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_readdata;
  assign write_end    = (state_q == S_WRITE);
`endif

  byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .take_i      (take),
    .clear_i     ((state_q == S_IDLE) || write_end),
    .byte_i      (st_data),
    .word_o      (pk_word),
    .be_o        (pk_be),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      st_ready_q <= 1'b0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            addr_q  <= cmd_base_addr;
            rem_q   <= cmd_byte_len;
            if (cmd_byte_len == '0) begin
              state_q <= S_FINISH;
            end else if (out_of_range) begin
              error_q <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              st_ready_q <= 1'b1;
              state_q    <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (take) begin
            rem_q <= rem_q - LEN_W'(1);
            if (word_full || last_byte) begin
              st_ready_q <= 1'b0;
              cs_q       <= 1'b1;
              wr_q       <= 1'b1;
              state_q    <= S_WRITE;
            end
          end
        end
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
        S_WRITE: begin
          wr_q    <= 1'b0;
          state_q <= S_VRD;
        end
        S_VRD: begin
          cs_q    <= 1'b0;
          state_q <= S_VCMP;
        end
        S_VCMP: begin
          // Read data arrives here after the one-cycle RAM latency.
          if (mismatch) error_q <= 1'b1;
          addr_q <= addr_q + ADDR_W'(1);
          if (rem_q == '0) begin
            state_q <= S_FINISH;
          end else begin
            st_ready_q <= 1'b1;
            state_q    <= S_COLLECT;
          end
        end
`else
        S_WRITE: begin
          cs_q   <= 1'b0;
          wr_q   <= 1'b0;
          addr_q <= addr_q + ADDR_W'(1);
          if (rem_q == '0) begin
            state_q <= S_FINISH;
          end else begin
            st_ready_q <= 1'b1;
            state_q    <= S_COLLECT;
          end
        end
`endif
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign st_ready       = st_ready_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = pk_be;
  assign mem_chipselect = cs_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = pk_word;
  assign mem_clken      = 1'b1;

endmodule
